// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the RV32 core. It holds the architectural PC and
// picks the next fetch address, with stall, halt/resume and a retired-instruction count.
module pc_sequencer #(
   parameter int               XLEN         = 32,
   parameter int               PC_INC       = 1,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0040,
   parameter int               JALR_CLR_LSB = 0,
   parameter int               CNT_W        = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_stall,
   input  logic             i_branch,
   input  logic [2:0]       i_cond,
   input  logic             i_jal,
   input  logic             i_jalr,
   input  logic [XLEN-1:0]  i_op_a,
   input  logic [XLEN-1:0]  i_op_b,
   input  logic [XLEN-1:0]  i_imm,
   input  logic [XLEN-1:0]  i_jalr_base,
   input  logic             i_trap,
   input  logic             i_halt,
   input  logic             i_resume,
   output logic [XLEN-1:0]  o_pc,
   output logic [XLEN-1:0]  o_pc_link,
   output logic             o_taken,
   output logic             o_redirect,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_instret
);

   typedef enum logic {RUN, HALT} state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_pc;
   logic              r_redirect;
   logic              r_halted;
   logic [CNT_W-1:0]  r_instret;

   logic              w_condTrue;
   logic [XLEN-1:0]   w_pcSeq;
   logic [XLEN-1:0]   w_pcRel;
   logic [XLEN-1:0]   w_jalrSum;
   logic [XLEN-1:0]   w_jalrTarget;

   assign w_pcSeq      = r_pc + XLEN'(PC_INC);
   assign w_pcRel      = r_pc + i_imm;
   assign w_jalrSum    = i_jalr_base + i_imm;
   assign w_jalrTarget = (JALR_CLR_LSB != 0) ? {w_jalrSum[XLEN-1:1], 1'b0} : w_jalrSum;

   // Codes 010 and 011 are not defined branch conditions and never take
   always_comb begin
      w_condTrue = 1'b0;
      case (i_cond)
         3'b000:  w_condTrue = (i_op_a == i_op_b);
         3'b001:  w_condTrue = (i_op_a != i_op_b);
         3'b100:  w_condTrue = ($signed(i_op_a) <  $signed(i_op_b));
         3'b101:  w_condTrue = ($signed(i_op_a) >= $signed(i_op_b));
         3'b110:  w_condTrue = (i_op_a <  i_op_b);
         3'b111:  w_condTrue = (i_op_a >= i_op_b);
         default: w_condTrue = 1'b0;
      endcase
   end

   assign o_taken = i_branch & w_condTrue;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= RUN;
         r_pc       <= RESET_VECTOR;
         r_redirect <= 1'b0;
         r_halted   <= 1'b0;
         r_instret  <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (i_trap) begin
                  r_pc       <= TRAP_VECTOR;
                  r_redirect <= 1'b1;
               end else if (i_stall) begin
                  r_redirect <= 1'b0;
               end else begin
                  r_instret <= r_instret + CNT_W'(1);
                  if (i_halt) begin
                     r_pc       <= w_pcSeq;
                     r_state    <= HALT;
                     r_halted   <= 1'b1;
                     r_redirect <= 1'b0;
                  end else if (i_jalr) begin
                     r_pc       <= w_jalrTarget;
                     r_redirect <= 1'b1;
                  end else if (i_jal || o_taken) begin
                     r_pc       <= w_pcRel;
                     r_redirect <= 1'b1;
                  end else begin
                     r_pc       <= w_pcSeq;
                     r_redirect <= 1'b0;
                  end
               end
            end
            HALT: begin
               r_redirect <= 1'b0;
               if (i_trap) begin
                  r_pc       <= TRAP_VECTOR;
                  r_state    <= RUN;
                  r_halted   <= 1'b0;
                  r_redirect <= 1'b1;
               end else if (i_resume) begin
                  r_state  <= RUN;
                  r_halted <= 1'b0;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_link  = w_pcSeq;
   assign o_redirect = r_redirect;
   assign o_halted   = r_halted;
   assign o_instret  = r_instret;

endmodule
